// File: rtl/bus_snoop_responder_if.sv
// Request channel (cache -> responder) and snoop response channel (responder -> cache).
interface bus_snoop_responder_if #(
   parameter int ADDR_W = 32
);
   logic              bus_valid;
   logic              bus_ready;
   logic [1:0]        bus_op;
   logic [ADDR_W-1:0] bus_addr;
   logic              snoop_valid;
   logic              snoop_ready;
   logic [1:0]        snoop_result;
   logic              snoop_c;

   modport master (
      output bus_valid, bus_op, bus_addr, snoop_ready,
      input  bus_ready, snoop_valid, snoop_result, snoop_c
   );

   modport slave (
      input  bus_valid, bus_op, bus_addr, snoop_ready,
      output bus_ready, snoop_valid, snoop_result, snoop_c
   );
endinterface

// File: rtl/bus_snoop_responder.sv
// Shared-bus snoop responder: one operation in flight, snoop result after a fixed latency,
// plus saturating per-operation statistics counters.
module bus_snoop_responder #(
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rstb,
   bus_snoop_responder_if.slave bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     read_cnt,
   output logic [CNT_W-1:0]     write_cnt,
   output logic [CNT_W-1:0]     inv_cnt,
   output logic [CNT_W-1:0]     rwim_cnt,
   output logic [CNT_W-1:0]     hitm_cnt
);

   localparam logic [1:0] OP_READ   = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_INV    = 2'd2;
   localparam logic [1:0] OP_RWIM   = 2'd3;
   localparam logic [1:0] RES_HIT   = 2'b00;
   localparam logic [1:0] RES_HITM  = 2'b01;
   localparam logic [1:0] RES_NOHIT = 2'b10;
   localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [1:0] snoop_decode(input logic [1:0] op, input logic [1:0] addr_lo);
      logic [1:0] res;
      if (op == OP_WRITE) begin
         res = RES_NOHIT;
      end else begin
         case (addr_lo)
            2'b00:   res = RES_HIT;
            2'b01:   res = RES_HITM;
            default: res = RES_NOHIT;
         endcase
      end
      return res;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            r_state;
   logic              r_bus_ready;
   logic              r_snoop_valid;
   logic [1:0]        r_snoop_result;
   logic              r_snoop_c;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_lat_cnt;
   logic [CNT_W-1:0]  r_read_cnt;
   logic [CNT_W-1:0]  r_write_cnt;
   logic [CNT_W-1:0]  r_inv_cnt;
   logic [CNT_W-1:0]  r_rwim_cnt;
   logic [CNT_W-1:0]  r_hitm_cnt;

   logic [1:0] w_res_now;
   logic [1:0] w_res_cap;
   logic       w_accept;
   logic       w_hitm_done;
   logic       w_unused_addr;

   assign w_res_now     = snoop_decode(bus.bus_op, bus.bus_addr[1:0]);
   assign w_res_cap     = snoop_decode(r_op, r_addr[1:0]);
   assign w_accept      = r_bus_ready & bus.bus_valid;
   assign w_hitm_done   = r_snoop_valid & bus.snoop_ready & (r_snoop_result == RES_HITM);
   assign w_unused_addr = ^r_addr[ADDR_W-1:2];

   // Request/response sequencing with registered handshake and snoop outputs
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_state        <= ST_IDLE;
         r_bus_ready    <= 1'b1;
         r_snoop_valid  <= 1'b0;
         r_snoop_result <= RES_NOHIT;
         r_snoop_c      <= 1'b0;
         r_op           <= OP_READ;
         r_addr         <= '0;
         r_lat_cnt      <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.bus_valid) begin
                  r_op        <= bus.bus_op;
                  r_addr      <= bus.bus_addr;
                  r_lat_cnt   <= LAT_M1;
                  r_bus_ready <= 1'b0;
                  if (LATENCY > 1) begin
                     r_state <= ST_WAIT;
                  end else begin
                     r_state        <= ST_RESP;
                     r_snoop_valid  <= 1'b1;
                     r_snoop_result <= w_res_now;
                     r_snoop_c      <= (w_res_now != RES_NOHIT);
                  end
               end
            end
            ST_WAIT: begin
               r_lat_cnt <= r_lat_cnt - 4'd1;
               if (r_lat_cnt == 4'd1) begin
                  r_state        <= ST_RESP;
                  r_snoop_valid  <= 1'b1;
                  r_snoop_result <= w_res_cap;
                  r_snoop_c      <= (w_res_cap != RES_NOHIT);
               end
            end
            ST_RESP: begin
               // Result stays on the bus after the handshake; only valid and C drop
               if (bus.snoop_ready) begin
                  r_state       <= ST_IDLE;
                  r_bus_ready   <= 1'b1;
                  r_snoop_valid <= 1'b0;
                  r_snoop_c     <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_bus_ready   <= 1'b1;
               r_snoop_valid <= 1'b0;
               r_snoop_c     <= 1'b0;
            end
         endcase
      end
   end

   // Saturating statistics; a clear in the same cycle as an increment wins
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_read_cnt  <= '0;
         r_write_cnt <= '0;
         r_inv_cnt   <= '0;
         r_rwim_cnt  <= '0;
         r_hitm_cnt  <= '0;
      end else if (cnt_clr) begin
         r_read_cnt  <= '0;
         r_write_cnt <= '0;
         r_inv_cnt   <= '0;
         r_rwim_cnt  <= '0;
         r_hitm_cnt  <= '0;
      end else begin
         if (w_accept) begin
            case (bus.bus_op)
               OP_READ:  r_read_cnt  <= sat_inc(r_read_cnt);
               OP_WRITE: r_write_cnt <= sat_inc(r_write_cnt);
               OP_INV:   r_inv_cnt   <= sat_inc(r_inv_cnt);
               OP_RWIM:  r_rwim_cnt  <= sat_inc(r_rwim_cnt);
               default:  r_read_cnt  <= r_read_cnt;
            endcase
         end
         if (w_hitm_done) begin
            r_hitm_cnt <= sat_inc(r_hitm_cnt);
         end
      end
   end

   assign bus.bus_ready    = r_bus_ready;
   assign bus.snoop_valid  = r_snoop_valid;
   assign bus.snoop_result = r_snoop_result;
   assign bus.snoop_c      = r_snoop_c;
   assign read_cnt         = r_read_cnt;
   assign write_cnt        = r_write_cnt;
   assign inv_cnt          = r_inv_cnt;
   assign rwim_cnt         = r_rwim_cnt;
   assign hitm_cnt         = r_hitm_cnt;

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Self-checking bench for bus_snoop_responder: three builds (LATENCY 2, LATENCY 1, CNT_W 4)
// checked against a transaction-level reference model.
module tb_bus_snoop_responder;
   localparam int ADDR_W = 32;
   localparam int LAT_A  = 2;
   localparam int LAT_B  = 1;
   localparam int LAT_C  = 3;
   localparam int CW_A   = 16;
   localparam int CW_C   = 4;

   logic clk = 1'b0;
   logic rstb;
   logic clr_a, clr_b, clr_c;
   logic [CW_A-1:0] rd_a, wr_a, inv_a, rwim_a, hitm_a;
   logic [CW_A-1:0] rd_b, wr_b, inv_b, rwim_b, hitm_b;
   logic [CW_C-1:0] rd_c, wr_c, inv_c, rwim_c, hitm_c;

   int chk_cnt  = 0;
   int fail_cnt = 0;
   int m_a [5];

   bus_snoop_responder_if #(.ADDR_W(ADDR_W)) ifa ();
   bus_snoop_responder_if #(.ADDR_W(ADDR_W)) ifb ();
   bus_snoop_responder_if #(.ADDR_W(ADDR_W)) ifc ();

   bus_snoop_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_A), .CNT_W(CW_A)) dut_a (
      .clk(clk), .rstb(rstb), .bus(ifa), .cnt_clr(clr_a),
      .read_cnt(rd_a), .write_cnt(wr_a), .inv_cnt(inv_a), .rwim_cnt(rwim_a), .hitm_cnt(hitm_a));
   bus_snoop_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_B), .CNT_W(CW_A)) dut_b (
      .clk(clk), .rstb(rstb), .bus(ifb), .cnt_clr(clr_b),
      .read_cnt(rd_b), .write_cnt(wr_b), .inv_cnt(inv_b), .rwim_cnt(rwim_b), .hitm_cnt(hitm_b));
   bus_snoop_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_C), .CNT_W(CW_C)) dut_c (
      .clk(clk), .rstb(rstb), .bus(ifc), .cnt_clr(clr_c),
      .read_cnt(rd_c), .write_cnt(wr_c), .inv_cnt(inv_c), .rwim_cnt(rwim_c), .hitm_cnt(hitm_c));

   always #5 clk = ~clk;

   // Reference rules: WRITE never hits; otherwise the low address bits pick HIT/HITM/NOHIT
   function automatic logic [1:0] exp_res(input logic [1:0] op, input logic [31:0] addr);
      if (op == 2'd1) return 2'b10;
      if (addr[1:0] == 2'b00) return 2'b00;
      if (addr[1:0] == 2'b01) return 2'b01;
      return 2'b10;
   endfunction

   function automatic int sat_up(input int v, input int w);
      return (v >= (1 << w) - 1) ? v : v + 1;
   endfunction

   task automatic run_op_a(input logic [1:0] op, input logic [31:0] addr, input int hold, input bit poke,
                           output int lat, output logic [1:0] res, output logic c,
                           output bit steady, output bit rdy_low, output bit tmo);
      int n;
      logic [CW_A-1:0] hitm0;
      lat = 0; res = 2'b11; c = 1'b0; steady = 1'b1; rdy_low = 1'b1; tmo = 1'b0;
      ifa.bus_op = op; ifa.bus_addr = addr; ifa.bus_valid = 1'b1; ifa.snoop_ready = (hold == 0);
      n = 0;
      @(negedge clk);
      while (ifa.bus_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (ifa.bus_ready !== 1'b1) begin tmo = 1'b1; ifa.bus_valid = 1'b0; return; end
      @(posedge clk); #1;
      ifa.bus_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk); n++;
         if (ifa.bus_ready !== 1'b0) rdy_low = 1'b0;
      end while (ifa.snoop_valid !== 1'b1 && n < 20);
      if (ifa.snoop_valid !== 1'b1) begin tmo = 1'b1; ifa.snoop_ready = 1'b0; return; end
      lat = n; res = ifa.snoop_result; c = ifa.snoop_c; hitm0 = hitm_a;
      if (poke) begin ifa.bus_valid = 1'b1; ifa.bus_op = 2'd0; ifa.bus_addr = $urandom; end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (ifa.snoop_valid !== 1'b1 || ifa.snoop_result !== res || ifa.snoop_c !== c || hitm_a !== hitm0)
            steady = 1'b0;
         if (ifa.bus_ready !== 1'b0) rdy_low = 1'b0;
      end
      ifa.snoop_ready = 1'b1;
      @(posedge clk); #1;
      ifa.snoop_ready = 1'b0; ifa.bus_valid = 1'b0;
   endtask

   task automatic run_op_c(input logic [1:0] op, input logic [31:0] addr, input bit clr,
                           output int lat, output logic [1:0] res);
      int n;
      lat = -1; res = 2'b11;
      ifc.bus_op = op; ifc.bus_addr = addr; ifc.bus_valid = 1'b1; ifc.snoop_ready = 1'b1; clr_c = clr;
      @(posedge clk); #1;
      ifc.bus_valid = 1'b0; clr_c = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (ifc.snoop_valid !== 1'b1 && n < 20);
      if (ifc.snoop_valid === 1'b1) begin lat = n; res = ifc.snoop_result; end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      chk_cnt++; if (ifa.bus_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_ready: got %b want 1", ifa.bus_ready); end
      chk_cnt++; if (ifa.snoop_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b want 0", ifa.snoop_valid); end
      chk_cnt++; if (ifa.snoop_result !== 2'b10) begin fail_cnt++; $display("FAIL reset_result: got %b want 10", ifa.snoop_result); end
      chk_cnt++; if (ifa.snoop_c !== 1'b0) begin fail_cnt++; $display("FAIL reset_c: got %b want 0", ifa.snoop_c); end
      chk_cnt++; if ({rd_a, wr_a, inv_a, rwim_a, hitm_a} !== '0) begin fail_cnt++; $display("FAIL reset_counters: got nonzero counters, want 0"); end
      rstb = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int lat; logic [1:0] res; logic c; bit st, rl, tmo;
      run_op_a(2'd0, 32'h1000_0040, 0, 1'b0, lat, res, c, st, rl, tmo);
      m_a[0] = sat_up(m_a[0], CW_A);
      chk_cnt++; if (tmo !== 1'b0 || lat !== LAT_A) begin fail_cnt++; $display("FAIL read_latency: got %0d (timeout %b) want %0d", lat, tmo, LAT_A); end
      chk_cnt++; if (res !== 2'b00 || c !== 1'b1) begin fail_cnt++; $display("FAIL read_result: got %b c=%b want 00 c=1", res, c); end
      chk_cnt++; if (rl !== 1'b1) begin fail_cnt++; $display("FAIL read_ready_low: bus_ready rose before the response handshake"); end
      @(negedge clk);
      chk_cnt++; if (ifa.snoop_valid !== 1'b0 || ifa.snoop_c !== 1'b0 || ifa.bus_ready !== 1'b1) begin
         fail_cnt++; $display("FAIL read_post: valid=%b c=%b ready=%b want 0 0 1", ifa.snoop_valid, ifa.snoop_c, ifa.bus_ready); end
      chk_cnt++; if (rd_a !== m_a[0]) begin fail_cnt++; $display("FAIL read_cnt: got %0d want %0d", rd_a, m_a[0]); end
      @(posedge clk); #1;
   endtask

   task automatic test_mixed_ops();
      logic [1:0]  ops [3] = '{2'd3, 2'd2, 2'd1};
      logic [31:0] ads [3] = '{32'h0000_0041, 32'h0000_0042, 32'h0000_0041};
      int lat; logic [1:0] res, er; logic c; bit st, rl, tmo;
      for (int i = 0; i < 3; i++) begin
         run_op_a(ops[i], ads[i], 0, 1'b0, lat, res, c, st, rl, tmo);
         er = exp_res(ops[i], ads[i]);
         m_a[ops[i]] = sat_up(m_a[ops[i]], CW_A);
         if (er == 2'b01) m_a[4] = sat_up(m_a[4], CW_A);
         chk_cnt++; if (tmo !== 1'b0 || res !== er || c !== (er != 2'b10)) begin
            fail_cnt++; $display("FAIL mixed_result op%0d: got %b c=%b want %b c=%b", ops[i], res, c, er, (er != 2'b10)); end
      end
      @(negedge clk);
      chk_cnt++; if (rwim_a !== m_a[3] || inv_a !== m_a[2] || wr_a !== m_a[1] || hitm_a !== m_a[4]) begin
         fail_cnt++; $display("FAIL mixed_counters: got rwim=%0d inv=%0d wr=%0d hitm=%0d want %0d %0d %0d %0d",
                              rwim_a, inv_a, wr_a, hitm_a, m_a[3], m_a[2], m_a[1], m_a[4]); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int lat; logic [1:0] res; logic c; bit st, rl, tmo;
      run_op_a(2'd0, 32'h0000_1235, 5, 1'b1, lat, res, c, st, rl, tmo);
      m_a[0] = sat_up(m_a[0], CW_A);
      m_a[4] = sat_up(m_a[4], CW_A);
      chk_cnt++; if (tmo !== 1'b0 || res !== 2'b01 || c !== 1'b1) begin fail_cnt++; $display("FAIL bp_result: got %b c=%b want 01 c=1", res, c); end
      chk_cnt++; if (st !== 1'b1) begin fail_cnt++; $display("FAIL bp_stable: response or hitm_cnt changed while stalled"); end
      chk_cnt++; if (rl !== 1'b1) begin fail_cnt++; $display("FAIL bp_ready: bus_ready rose while stalled"); end
      @(negedge clk);
      chk_cnt++; if (rd_a !== m_a[0] || hitm_a !== m_a[4]) begin
         fail_cnt++; $display("FAIL bp_counters: got rd=%0d hitm=%0d want %0d %0d", rd_a, hitm_a, m_a[0], m_a[4]); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat; logic [1:0] res, er, op; logic [31:0] addr; logic c; bit st, rl, tmo;
      logic [CW_A-1:0] obs [5];
      for (int k = 0; k < 30; k++) begin
         op = 2'($urandom_range(0, 3)); addr = $urandom;
         run_op_a(op, addr, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, res, c, st, rl, tmo);
         er = exp_res(op, addr);
         m_a[op] = sat_up(m_a[op], CW_A);
         if (er == 2'b01) m_a[4] = sat_up(m_a[4], CW_A);
         chk_cnt++; if (tmo !== 1'b0 || lat !== LAT_A || res !== er || c !== (er != 2'b10) || st !== 1'b1) begin
            fail_cnt++; $display("FAIL rand_op%0d: op=%0d addr=%h lat=%0d res=%b c=%b stable=%b want lat=%0d res=%b",
                                 k, op, addr, lat, res, c, st, LAT_A, er); end
         @(negedge clk);
         obs = '{rd_a, wr_a, inv_a, rwim_a, hitm_a};
         for (int j = 0; j < 5; j++) begin
            chk_cnt++; if (obs[j] !== m_a[j]) begin fail_cnt++; $display("FAIL rand_cnt%0d idx%0d: got %0d want %0d", k, j, obs[j], m_a[j]); end
         end
         @(posedge clk); #1;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] qo [$]; logic [31:0] qa [$];
      logic [31:0] addr; logic [1:0] er; bit rdy_exp;
      addr = $urandom;
      ifb.snoop_ready = 1'b1; ifb.bus_valid = 1'b1; ifb.bus_op = 2'd0; ifb.bus_addr = addr;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rdy_exp = (k % 2 == 0);
         chk_cnt++; if (ifb.bus_ready !== rdy_exp || ifb.snoop_valid !== !rdy_exp) begin
            fail_cnt++; $display("FAIL b2b_cycle%0d: ready=%b valid=%b want %b %b", k, ifb.bus_ready, ifb.snoop_valid, rdy_exp, !rdy_exp); end
         if (ifb.snoop_valid === 1'b1 && qo.size() > 0) begin
            er = exp_res(qo[0], qa[0]);
            chk_cnt++; if (ifb.snoop_result !== er) begin fail_cnt++; $display("FAIL b2b_result%0d: got %b want %b", k, ifb.snoop_result, er); end
            void'(qo.pop_front()); void'(qa.pop_front());
         end
         @(posedge clk); #1;
         if (rdy_exp) begin
            qo.push_back(2'd0); qa.push_back(addr);
            addr = $urandom; ifb.bus_addr = addr;
         end
      end
      ifb.bus_valid = 1'b0; ifb.snoop_ready = 1'b0;
      @(negedge clk);
      chk_cnt++; if (rd_b !== 16'd3) begin fail_cnt++; $display("FAIL b2b_read_cnt: got %0d want 3", rd_b); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int lat, bad; logic [1:0] res;
      bad = 0;
      for (int k = 0; k < 17; k++) begin
         run_op_c(2'd0, {$urandom} & 32'hFFFF_FFFC | 32'h1, 1'b0, lat, res);
         if (lat !== LAT_C || res !== 2'b01) bad++;
      end
      @(negedge clk);
      chk_cnt++; if (bad !== 0) begin fail_cnt++; $display("FAIL sat_responses: %0d bad responses, want 0", bad); end
      chk_cnt++; if (rd_c !== 4'd15 || hitm_c !== 4'd15) begin fail_cnt++; $display("FAIL sat_value: got rd=%0d hitm=%0d want 15 15", rd_c, hitm_c); end
      @(posedge clk); #1;
      run_op_c(2'd0, 32'h0000_0005, 1'b1, lat, res);
      chk_cnt++; if (lat !== LAT_C || res !== 2'b01) begin fail_cnt++; $display("FAIL clr_response: got lat=%0d res=%b want %0d 01", lat, res, LAT_C); end
      @(negedge clk);
      chk_cnt++; if (rd_c !== 4'd0 || hitm_c !== 4'd1) begin fail_cnt++; $display("FAIL clr_counters: got rd=%0d hitm=%0d want 0 1", rd_c, hitm_c); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      int lat, stale; logic [1:0] res; logic c; bit st, rl, tmo;
      ifa.bus_op = 2'd0; ifa.bus_addr = 32'h0000_0100; ifa.bus_valid = 1'b1; ifa.snoop_ready = 1'b1;
      @(posedge clk); #1;
      ifa.bus_valid = 1'b0;
      #2; rstb = 1'b1; #1;
      chk_cnt++; if (ifa.snoop_valid !== 1'b0 || ifa.bus_ready !== 1'b1) begin
         fail_cnt++; $display("FAIL midreset_async: valid=%b ready=%b want 0 1", ifa.snoop_valid, ifa.bus_ready); end
      for (int j = 0; j < 5; j++) m_a[j] = 0;
      @(negedge clk); rstb = 1'b0;
      stale = 0;
      repeat (4) begin @(negedge clk); if (ifa.snoop_valid !== 1'b0) stale++; end
      chk_cnt++; if (stale !== 0 || rd_a !== 16'd0) begin fail_cnt++; $display("FAIL midreset_stale: %0d stale cycles rd=%0d want 0 0", stale, rd_a); end
      @(posedge clk); #1;
      run_op_a(2'd0, 32'h0000_0200, 0, 1'b0, lat, res, c, st, rl, tmo);
      m_a[0] = sat_up(m_a[0], CW_A);
      chk_cnt++; if (tmo !== 1'b0 || lat !== LAT_A || res !== 2'b00) begin fail_cnt++; $display("FAIL midreset_next: lat=%0d res=%b want %0d 00", lat, res, LAT_A); end
      @(negedge clk);
      chk_cnt++; if (rd_a !== m_a[0]) begin fail_cnt++; $display("FAIL midreset_cnt: got %0d want %0d", rd_a, m_a[0]); end
      @(posedge clk); #1;
   endtask

   initial begin
      rstb = 1'b1; clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      ifa.bus_valid = 1'b0; ifa.bus_op = 2'd0; ifa.bus_addr = '0; ifa.snoop_ready = 1'b0;
      ifb.bus_valid = 1'b0; ifb.bus_op = 2'd0; ifb.bus_addr = '0; ifb.snoop_ready = 1'b0;
      ifc.bus_valid = 1'b0; ifc.bus_op = 2'd0; ifc.bus_addr = '0; ifc.snoop_ready = 1'b0;
      for (int j = 0; j < 5; j++) m_a[j] = 0;
      repeat (3) @(posedge clk);
      test_reset();
      test_read();
      test_mixed_ops();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_saturation();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
